// File: rtl/block_deinterleaver.sv
// rtl/block_deinterleaver.sv - ping-pong ROWS x COLS bit deinterleaver, column-major in, row-major out.
// Optional DEINTL_SOF_RESYNC_EN: i_sof restarts the write block and sets sticky o_resync_err.
module block_deinterleaver #(
  parameter int ROWS       = 128,
  parameter int COLS       = 128,
  parameter int ADDR_WIDTH = 14
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_valid,
  input  logic i_data,
  input  logic i_sof,
  output logic i_ready,
  output logic o_valid,
  output logic o_data,
  output logic o_sof,
  output logic o_eof,
  input  logic o_ready
`ifdef DEINTL_SOF_RESYNC_EN
  ,
  output logic o_resync_err
`endif
);
  localparam int N     = ROWS * COLS;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);
  localparam logic [RW-1:0]         LAST_R    = RW'(ROWS - 1);
  localparam logic [CW-1:0]         LAST_C    = CW'(COLS - 1);

  if (N > DEPTH) begin : g_size_check
    $error("block_deinterleaver: ROWS*COLS exceeds 2**ADDR_WIDTH");
  end

  typedef enum logic {RD_IDLE, RD_RUN} rd_state_t;

  logic                  r_bank0 [DEPTH];
  logic                  r_bank1 [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_cnt;
  logic                  r_wb;
  logic                  r_rb;
  logic [1:0]            r_bank_full;
  logic [RW-1:0]         r_rd_r;
  logic [CW-1:0]         r_rd_c;
  rd_state_t             r_state;
  rd_state_t             w_state_nxt;
  logic                  r_valid;
  logic                  r_data;
  logic                  r_sof;
  logic                  r_eof;
  logic                  w_wr_en;
  logic                  w_wr_last;
  logic                  w_rd_issue;
  logic                  w_rd_last;
  logic                  w_rd_bit;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [1:0]            w_full_set;
  logic [1:0]            w_full_clr;

  assign i_ready = !r_bank_full[r_wb];
  assign w_wr_en = i_valid && i_ready;

`ifdef DEINTL_SOF_RESYNC_EN
  logic r_resync_err;
  // A start marker always lands at address 0, abandoning any partial block.
  assign w_wr_addr    = i_sof ? '0 : r_wr_cnt;
  assign o_resync_err = r_resync_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_resync_err <= 1'b0;
    end else if (w_wr_en && i_sof && (r_wr_cnt != '0)) begin
      r_resync_err <= 1'b1;
    end
  end
`else
  logic w_unused_sof;
  assign w_unused_sof = i_sof;
  assign w_wr_addr    = r_wr_cnt;
`endif

  assign w_wr_last = (w_wr_addr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst_n && w_wr_en) begin
      if (r_wb) r_bank1[w_wr_addr] <= i_data;
      else      r_bank0[w_wr_addr] <= i_data;
    end
  end

  // Output index j = r*COLS + c lives at bank address c*ROWS + r.
  assign w_rd_addr = ADDR_WIDTH'(r_rd_c) * ADDR_WIDTH'(ROWS) + ADDR_WIDTH'(r_rd_r);
  assign w_rd_bit  = r_rb ? r_bank1[w_rd_addr] : r_bank0[w_rd_addr];
  assign w_rd_last = (r_rd_r == LAST_R) && (r_rd_c == LAST_C);

  always_comb begin
    w_state_nxt = r_state;
    w_rd_issue  = 1'b0;
    case (r_state)
      RD_IDLE: begin
        if (r_bank_full[r_rb]) w_state_nxt = RD_RUN;
      end
      RD_RUN: begin
        if (!r_valid || o_ready) begin
          w_rd_issue = 1'b1;
          if (w_rd_last) w_state_nxt = r_bank_full[!r_rb] ? RD_RUN : RD_IDLE;
        end
      end
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  assign w_full_set = {2{w_wr_en && w_wr_last}} & {r_wb, !r_wb};
  assign w_full_clr = {2{w_rd_issue && w_rd_last}} & {r_rb, !r_rb};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= RD_IDLE;
      r_wr_cnt    <= '0;
      r_wb        <= 1'b0;
      r_rb        <= 1'b0;
      r_rd_r      <= '0;
      r_rd_c      <= '0;
      r_bank_full <= 2'b00;
      r_valid     <= 1'b0;
      r_data      <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bank_full <= (r_bank_full & ~w_full_clr) | w_full_set;
      if (w_wr_en) begin
        r_wr_cnt <= w_wr_last ? '0 : w_wr_addr + ADDR_WIDTH'(1);
        if (w_wr_last) r_wb <= !r_wb;
      end
      if (w_rd_issue) begin
        r_valid <= 1'b1;
        r_data  <= w_rd_bit;
        r_sof   <= (r_rd_r == '0) && (r_rd_c == '0);
        r_eof   <= w_rd_last;
        if (w_rd_last) begin
          r_rd_r <= '0;
          r_rd_c <= '0;
          r_rb   <= !r_rb;
        end else if (r_rd_c == LAST_C) begin
          r_rd_c <= '0;
          r_rd_r <= r_rd_r + RW'(1);
        end else begin
          r_rd_c <= r_rd_c + CW'(1);
        end
      end else if (o_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_sof   = r_sof;
  assign o_eof   = r_eof;

endmodule

// File: tb/tb_block_deinterleaver.sv
// tb/tb_block_deinterleaver.sv - bench for block_deinterleaver: 4x3 directed tests plus 8x8 random traffic.
module tb_block_deinterleaver;
  localparam int AR = 4, AC = 3, AN = 12;
  localparam int BR = 8, BC = 8, BN = 64, BBLK = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_i_valid = 1'b0, a_i_data = 1'b0, a_i_sof = 1'b0, a_o_ready = 1'b1;
  logic a_i_ready, a_o_valid, a_o_data, a_o_sof, a_o_eof;
  logic b_i_valid = 1'b0, b_i_data = 1'b0, b_i_sof = 1'b0, b_o_ready = 1'b1;
  logic b_i_ready, b_o_valid, b_o_data, b_o_sof, b_o_eof;
`ifdef DEINTL_SOF_RESYNC_EN
  logic a_o_resync_err, b_o_resync_err;
`endif

  block_deinterleaver #(.ROWS(AR), .COLS(AC), .ADDR_WIDTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .i_valid(a_i_valid), .i_data(a_i_data), .i_sof(a_i_sof),
    .i_ready(a_i_ready), .o_valid(a_o_valid), .o_data(a_o_data), .o_sof(a_o_sof),
    .o_eof(a_o_eof), .o_ready(a_o_ready)
`ifdef DEINTL_SOF_RESYNC_EN
    , .o_resync_err(a_o_resync_err)
`endif
  );

  block_deinterleaver #(.ROWS(BR), .COLS(BC), .ADDR_WIDTH(6)) u_b (
    .clk(clk), .rst_n(rst_n), .i_valid(b_i_valid), .i_data(b_i_data), .i_sof(b_i_sof),
    .i_ready(b_i_ready), .o_valid(b_o_valid), .o_data(b_o_data), .o_sof(b_o_sof),
    .o_eof(b_o_eof), .o_ready(b_o_ready)
`ifdef DEINTL_SOF_RESYNC_EN
    , .o_resync_err(b_o_resync_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Model state: bits of the block being written, and expected {sof,eof,data} in output order.
  logic       a_in[$];
  logic       b_in[$];
  logic [2:0] a_exp[$];
  logic [2:0] b_exp[$];
  logic       a_cap_d[$], a_cap_s[$], a_cap_e[$];
  int         a_cap_t[$];
  int         b_out_cnt = 0, b_sof_cnt = 0, b_eof_cnt = 0;
  logic       a_hold = 1'b0, b_hold = 1'b0;
  logic [2:0] a_hv = 3'b0, b_hv = 3'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event not seen within its bound", name);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      a_in.delete(); a_exp.delete(); b_in.delete(); b_exp.delete();
      a_hold <= 1'b0;
      b_hold <= 1'b0;
    end else begin
      if (a_hold) chk("a_hold_stable", {a_o_valid, a_o_sof, a_o_eof, a_o_data}, {1'b1, a_hv});
      if (b_hold) chk("b_hold_stable", {b_o_valid, b_o_sof, b_o_eof, b_o_data}, {1'b1, b_hv});
      a_hold <= a_o_valid && !a_o_ready;
      a_hv   <= {a_o_sof, a_o_eof, a_o_data};
      b_hold <= b_o_valid && !b_o_ready;
      b_hv   <= {b_o_sof, b_o_eof, b_o_data};

      if (a_o_valid && a_o_ready) begin
        if (a_exp.size() == 0) fail("a_extra_output");
        else begin
          chk("a_data", a_o_data, a_exp[0][0]);
          chk("a_sof", a_o_sof, a_exp[0][2]);
          chk("a_eof", a_o_eof, a_exp[0][1]);
          void'(a_exp.pop_front());
        end
        a_cap_d.push_back(a_o_data);
        a_cap_s.push_back(a_o_sof);
        a_cap_e.push_back(a_o_eof);
        a_cap_t.push_back(cyc);
      end
      if (b_o_valid && b_o_ready) begin
        if (b_exp.size() == 0) fail("b_extra_output");
        else begin
          chk("b_data", b_o_data, b_exp[0][0]);
          chk("b_sof", b_o_sof, b_exp[0][2]);
          chk("b_eof", b_o_eof, b_exp[0][1]);
          void'(b_exp.pop_front());
        end
        b_out_cnt <= b_out_cnt + 1;
        b_sof_cnt <= b_sof_cnt + int'(b_o_sof);
        b_eof_cnt <= b_eof_cnt + int'(b_o_eof);
      end

      if (a_i_valid && a_i_ready) begin
`ifdef DEINTL_SOF_RESYNC_EN
        if (a_i_sof) a_in.delete();
`endif
        a_in.push_back(a_i_data);
        if (a_in.size() == AN) begin
          for (int j = 0; j < AN; j++)
            a_exp.push_back({j == 0, j == AN - 1, a_in[(j % AC) * AR + j / AC]});
          a_in.delete();
        end
      end
      if (b_i_valid && b_i_ready) begin
        b_in.push_back(b_i_data);
        if (b_in.size() == BN) begin
          for (int j = 0; j < BN; j++)
            b_exp.push_back({j == 0, j == BN - 1, b_in[(j % BC) * BR + j / BC]});
          b_in.delete();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic d, input logic s);
    int t;
    t = 0;
    a_i_valid = 1'b1;
    a_i_data  = d;
    a_i_sof   = s;
    while (!a_i_ready && t < 100) begin
      tick();
      t++;
    end
    if (t == 100) fail("a_send_stall");
    tick();
    a_i_valid = 1'b0;
    a_i_sof   = 1'b0;
  endtask

  task automatic drain_a();
    int t;
    t = 0;
    while ((a_exp.size() != 0 || a_o_valid) && t < 300) begin
      tick();
      t++;
    end
    if (t == 300) fail("a_drain");
  endtask

  task automatic clr_cap();
    a_cap_d.delete(); a_cap_s.delete(); a_cap_e.delete(); a_cap_t.delete();
  endtask

  task automatic cap_vecs(output logic [31:0] d, output logic [31:0] s, output logic [31:0] e);
    d = '0; s = '0; e = '0;
    for (int i = 0; i < a_cap_d.size() && i < 32; i++) begin
      d[i] = a_cap_d[i];
      s[i] = a_cap_s[i];
      e[i] = a_cap_e[i];
    end
  endtask

  initial begin
    logic [31:0] vd, vs, ve;
    int early, seen, sent, t;

    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_o_valid", a_o_valid, 0);
    chk("rst_o_data", a_o_data, 0);
    chk("rst_o_sof", a_o_sof, 0);
    chk("rst_o_eof", a_o_eof, 0);
    chk("rst_i_ready", a_i_ready, 1);
`ifdef DEINTL_SOF_RESYNC_EN
    chk("rst_resync_err", a_o_resync_err, 0);
`endif

    // One-hot at k=1 must surface at j=3; first o_valid two edges after the last input edge.
    clr_cap();
    for (int k = 0; k < AN; k++) send_a(k == 1, 1'b0);
    chk("lat_edge0", a_o_valid, 0);
    tick();
    chk("lat_edge1", a_o_valid, 0);
    tick();
    chk("lat_edge2", a_o_valid, 1);
    chk("lat_first_sof", a_o_sof, 1);
    drain_a();
    cap_vecs(vd, vs, ve);
    chk("t1_count", a_cap_d.size(), 12);
    chk("t1_data", vd, 32'h008);
    chk("t1_sof_pos", vs, 32'h001);
    chk("t1_eof_pos", ve, 32'h800);

    // Two back-to-back blocks of k%2: rows 1 and 3 high, no bubble between blocks.
    clr_cap();
    for (int k = 0; k < 2 * AN; k++) begin
      chk("t2_i_ready", a_i_ready, 1);
      send_a(k[0], 1'b0);
    end
    drain_a();
    cap_vecs(vd, vs, ve);
    chk("t2_count", a_cap_d.size(), 24);
    chk("t2_data", vd, 32'hE38E38);
    chk("t2_sof_pos", vs, 32'h001001);
    chk("t2_eof_pos", ve, 32'h800800);
    if (a_cap_t.size() == 24) chk("t2_no_gap", a_cap_t[23] - a_cap_t[0], 23);
    else fail("t2_no_gap");

    // Back-pressure with both banks filled; i_ready returns right after the first eof read.
    clr_cap();
    a_o_ready = 1'b0;
    for (int k = 0; k < 2 * AN; k++) send_a((k % 3) == 0, 1'b0);
    chk("t3_i_ready_low", a_i_ready, 0);
    chk("t3_o_valid_held", a_o_valid, 1);
    chk("t3_first_sof", a_o_sof, 1);
    repeat (4) tick();
    chk("t3_i_ready_still_low", a_i_ready, 0);
    a_o_ready = 1'b1;
    early = 0;
    seen  = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (seen == 0 && a_o_valid && a_o_eof) begin
        chk("t3_i_ready_after_eof", a_i_ready, 1);
        seen = 1;
      end else if (seen == 0 && a_i_ready) begin
        early++;
      end
    end
    if (seen == 0) fail("t3_first_eof");
    chk("t3_i_ready_early", early, 0);
    drain_a();
    cap_vecs(vd, vs, ve);
    chk("t3_count", a_cap_d.size(), 24);
    chk("t3_data", vd, 32'h2A12A1);

    // Reset after 7 of 12 bits, then a fresh block whose only one (k=11) lands at j=11.
    for (int k = 0; k < 7; k++) send_a(1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("t5_o_valid", a_o_valid, 0);
    chk("t5_i_ready", a_i_ready, 1);
    rst_n = 1'b1;
    clr_cap();
    for (int k = 0; k < AN; k++) send_a(k == 11, 1'b0);
    drain_a();
    cap_vecs(vd, vs, ve);
    chk("t5_count", a_cap_d.size(), 12);
    chk("t5_data", vd, 32'h800);

`ifdef DEINTL_SOF_RESYNC_EN
    clr_cap();
    for (int k = 0; k < 5; k++) send_a(1'b1, 1'b0);
    chk("t6_err_before", a_o_resync_err, 0);
    send_a(1'b0, 1'b1);
    for (int k = 1; k < AN; k++) send_a(k == 1, 1'b0);
    chk("t6_err_after", a_o_resync_err, 1);
    drain_a();
    cap_vecs(vd, vs, ve);
    chk("t6_count", a_cap_d.size(), 12);
    chk("t6_data", vd, 32'h008);
`endif

    // 8x8 random traffic: 20 blocks with random i_valid and o_ready.
    sent = 0;
    t    = 0;
    while (sent < BN * BBLK && t < 20000) begin
      b_i_valid = 1'($urandom_range(0, 1));
      b_i_data  = 1'($urandom_range(0, 1));
      b_o_ready = 1'($urandom_range(0, 1));
      if (b_i_valid && b_i_ready) sent++;
      tick();
      t++;
    end
    b_i_valid = 1'b0;
    if (sent < BN * BBLK) fail("b_send_budget");
    t = 0;
    while (b_out_cnt < BN * BBLK && t < 5000) begin
      b_o_ready = 1'($urandom_range(0, 1));
      tick();
      t++;
    end
    b_o_ready = 1'b1;
    repeat (3) tick();
    chk("b_out_count", b_out_cnt, BN * BBLK);
    chk("b_sof_count", b_sof_cnt, BBLK);
    chk("b_eof_count", b_eof_cnt, BBLK);
    chk("b_model_drained", b_exp.size(), 0);
    chk("b_o_valid_idle", b_o_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
